// File: rtl/branch_ctrl_fsm_if.sv
// Handshake bundle between the control unit and the branch controller:
// request/opcode/condition result in, compare/PC control and statistics out.
interface branch_ctrl_fsm_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [5:0]       opcode;
    logic             taken;
    logic             alu_cmp;
    logic             cmp_en;
    logic [1:0]       cmp_op;
    logic             pc_write;
    logic [1:0]       pc_source;
    logic             busy;
    logic             done;
    logic             invalid;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] nt_cnt;

    modport master (
        output start, opcode, taken,
        input  alu_cmp, cmp_en, cmp_op, pc_write, pc_source,
        input  busy, done, invalid, taken_cnt, nt_cnt
    );

    modport slave (
        input  start, opcode, taken,
        output alu_cmp, cmp_en, cmp_op, pc_write, pc_source,
        output busy, done, invalid, taken_cnt, nt_cnt
    );
endinterface

// File: rtl/branch_ctrl_fsm.sv
// Conditional-branch sequencer: compare, evaluate, write PC, with saturating
// taken / not-taken statistics counters.
module branch_ctrl_fsm #(
    parameter int         CNT_W  = 16,
    parameter logic [1:0] BR_SRC = 2'b01
) (
    input logic              clk,
    input logic              reset,
    branch_ctrl_fsm_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        EVAL    = 2'd2,
        WRITE   = 2'd3
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [1:0] cmp_op_reg;
    logic       taken_reg;
    logic       invalid_reg;
    logic       is_branch;
    logic       accept;

    logic       alu_cmp;
    logic       cmp_en;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       busy;
    logic       done;

    // BEQ/BNE/BLE/BGT occupy opcodes 6'h04..6'h07
    assign is_branch = (bus.opcode[5:2] == 4'b0001);
    assign accept    = (state_reg == IDLE) && bus.start && is_branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = COMPARE;
            COMPARE: state_next = EVAL;
            EVAL:    state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_op_reg  <= 2'b00;
            taken_reg   <= 1'b0;
            invalid_reg <= 1'b0;
        end else begin
            invalid_reg <= (state_reg == IDLE) && bus.start && !is_branch;
            if (accept) begin
                cmp_op_reg <= bus.opcode[1:0];
            end
            if (state_reg == EVAL) begin
                taken_reg <= bus.taken;
            end
        end
    end

    // Instance 0 counts taken outcomes, instance 1 not-taken; both saturate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        localparam logic SENSE = (gi == 0);
        logic [CNT_W-1:0] cnt_reg;
        logic             inc;

        assign inc = (state_reg == EVAL) && (bus.taken == SENSE);

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_reg <= '0;
            end else if (inc && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    // Reset masks the decoded outputs so an aborted branch never leaks a strobe
    always_comb begin
        alu_cmp   = 1'b0;
        cmp_en    = 1'b0;
        pc_write  = 1'b0;
        pc_source = 2'b00;
        busy      = 1'b0;
        done      = 1'b0;
        if (!reset) begin
            case (state_reg)
                COMPARE: begin
                    alu_cmp = 1'b1;
                    busy    = 1'b1;
                end
                EVAL: begin
                    alu_cmp = 1'b1;
                    cmp_en  = 1'b1;
                    busy    = 1'b1;
                end
                WRITE: begin
                    busy      = 1'b1;
                    done      = 1'b1;
                    pc_write  = taken_reg;
                    pc_source = taken_reg ? BR_SRC : 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_cmp   = alu_cmp;
    assign bus.cmp_en    = cmp_en;
    assign bus.pc_write  = pc_write;
    assign bus.pc_source = pc_source;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.cmp_op    = reset ? 2'b00 : cmp_op_reg;
    assign bus.invalid   = !reset && invalid_reg;
    assign bus.taken_cnt = reset ? '0 : g_cnt[0].cnt_reg;
    assign bus.nt_cnt    = reset ? '0 : g_cnt[1].cnt_reg;
endmodule

// File: tb/tb_branch_ctrl_fsm.sv
// Directed vector table, counter saturation sequence and randomized run
// against a cycle-timeline model of the branch controller.
module tb_branch_ctrl_fsm;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] opcode;
    logic       taken;

    always #5 clk = ~clk;

    branch_ctrl_fsm_if #(.CNT_W(16)) bus_a ();
    branch_ctrl_fsm_if #(.CNT_W(2))  bus_b ();

    assign bus_a.start  = start;
    assign bus_a.opcode = opcode;
    assign bus_a.taken  = taken;
    assign bus_b.start  = start;
    assign bus_b.opcode = opcode;
    assign bus_b.taken  = taken;

    branch_ctrl_fsm #(.CNT_W(16), .BR_SRC(2'b01)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    branch_ctrl_fsm #(.CNT_W(2), .BR_SRC(2'b01)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check_outs(input string tag, input bit busy, input bit alu, input bit en,
                              input bit dn, input bit pcw, input bit [1:0] pcs, input bit inv,
                              input bit [1:0] cop, input int t, input int n);
        chk({tag, ".busy"},      bus_a.busy,      busy);
        chk({tag, ".alu_cmp"},   bus_a.alu_cmp,   alu);
        chk({tag, ".cmp_en"},    bus_a.cmp_en,    en);
        chk({tag, ".done"},      bus_a.done,      dn);
        chk({tag, ".pc_write"},  bus_a.pc_write,  pcw);
        chk({tag, ".pc_source"}, bus_a.pc_source, pcs);
        chk({tag, ".invalid"},   bus_a.invalid,   inv);
        chk({tag, ".cmp_op"},    bus_a.cmp_op,    cop);
        chk({tag, ".taken_cnt"}, bus_a.taken_cnt, sat(t, 16));
        chk({tag, ".nt_cnt"},    bus_a.nt_cnt,    sat(n, 16));
        chk({tag, ".b_done"},    bus_b.done,      dn);
        chk({tag, ".b_taken_cnt"}, bus_b.taken_cnt, sat(t, 2));
        chk({tag, ".b_nt_cnt"},    bus_b.nt_cnt,    sat(n, 2));
    endtask

    // Reference model: a branch accepted at some edge occupies the three
    // following cycles (offset 1 compare, 2 evaluate, 3 write-back).
    int       cyc  = 0;
    int       t0   = -1000;
    int       tcnt = 0;
    int       ncnt = 0;
    bit [1:0] m_op = 2'b00;
    bit       m_tk = 1'b0;
    bit       m_inv = 1'b0;

    function automatic int offs();
        return cyc - t0 + 1;
    endfunction

    task automatic model_edge();
        int  p;
        bit  bsy;
        bit  br;
        p   = offs();
        bsy = (p >= 1) && (p <= 3);
        br  = (opcode >= 6'h04) && (opcode <= 6'h07);
        if (reset) begin
            t0 = -1000; m_op = 2'b00; m_tk = 1'b0; m_inv = 1'b0; tcnt = 0; ncnt = 0;
        end else begin
            m_inv = !bsy && start && !br;
            if (p == 2) begin
                m_tk = taken;
                if (taken) tcnt++;
                else ncnt++;
            end
            if (!bsy && start && br) begin
                t0   = cyc + 1;
                m_op = 2'(opcode % 4);
            end
        end
        cyc++;
    endtask

    task automatic check_model(input string tag);
        int p;
        bit pcw;
        p = offs();
        if (reset) begin
            check_outs(tag, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        end else begin
            pcw = (p == 3) && m_tk;
            check_outs(tag, (p >= 1) && (p <= 3), (p == 1) || (p == 2), p == 2, p == 3,
                       pcw, pcw ? 2'b01 : 2'b00, m_inv, m_op, tcnt, ncnt);
        end
    endtask

    task automatic drive(input bit s, input bit [5:0] op, input bit tk, input bit rs);
        start = s; opcode = op; taken = tk; reset = rs;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    typedef struct {
        bit       s;
        bit [5:0] op;
        bit       tk;
        bit       rs;
        bit       busy, alu, en, dn, pcw;
        bit [1:0] pcs;
        bit       inv;
        bit [1:0] cop;
        int       t, n;
    } vec_t;

    function automatic vec_t mk(input bit s, input bit [5:0] op, input bit tk, input bit rs,
                                input bit busy, input bit alu, input bit en, input bit dn,
                                input bit pcw, input bit [1:0] pcs, input bit inv,
                                input bit [1:0] cop, input int t, input int n);
        vec_t v;
        v.s = s; v.op = op; v.tk = tk; v.rs = rs; v.busy = busy; v.alu = alu; v.en = en;
        v.dn = dn; v.pcw = pcw; v.pcs = pcs; v.inv = inv; v.cop = cop; v.t = t; v.n = n;
        return v;
    endfunction

    vec_t vecs[20];

    initial begin
        //            s  op     tk rs busy alu en dn pcw pcs   inv cop    t  n
        vecs[0]  = mk(0, 6'h00, 0, 1, 0,   0,  0, 0, 0,  2'b00, 0, 2'b00, 0, 0);
        vecs[1]  = mk(1, 6'h04, 0, 0, 0,   0,  0, 0, 0,  2'b00, 0, 2'b00, 0, 0);
        vecs[2]  = mk(0, 6'h00, 0, 0, 1,   1,  0, 0, 0,  2'b00, 0, 2'b00, 0, 0);
        vecs[3]  = mk(0, 6'h00, 1, 0, 1,   1,  1, 0, 0,  2'b00, 0, 2'b00, 0, 0);
        vecs[4]  = mk(0, 6'h00, 0, 0, 1,   0,  0, 1, 1,  2'b01, 0, 2'b00, 1, 0);
        vecs[5]  = mk(1, 6'h05, 0, 0, 0,   0,  0, 0, 0,  2'b00, 0, 2'b00, 1, 0);
        vecs[6]  = mk(1, 6'h07, 1, 0, 1,   1,  0, 0, 0,  2'b00, 0, 2'b01, 1, 0);
        vecs[7]  = mk(1, 6'h07, 0, 0, 1,   1,  1, 0, 0,  2'b00, 0, 2'b01, 1, 0);
        vecs[8]  = mk(1, 6'h07, 1, 0, 1,   0,  0, 1, 0,  2'b00, 0, 2'b01, 1, 1);
        vecs[9]  = mk(1, 6'h23, 0, 0, 0,   0,  0, 0, 0,  2'b00, 0, 2'b01, 1, 1);
        vecs[10] = mk(0, 6'h00, 0, 0, 0,   0,  0, 0, 0,  2'b00, 1, 2'b01, 1, 1);
        vecs[11] = mk(1, 6'h06, 0, 0, 0,   0,  0, 0, 0,  2'b00, 0, 2'b01, 1, 1);
        vecs[12] = mk(0, 6'h00, 1, 0, 1,   1,  0, 0, 0,  2'b00, 0, 2'b10, 1, 1);
        vecs[13] = mk(0, 6'h00, 1, 1, 0,   0,  0, 0, 0,  2'b00, 0, 2'b00, 0, 0);
        vecs[14] = mk(0, 6'h00, 0, 0, 0,   0,  0, 0, 0,  2'b00, 0, 2'b00, 0, 0);
        vecs[15] = mk(1, 6'h07, 0, 0, 0,   0,  0, 0, 0,  2'b00, 0, 2'b00, 0, 0);
        vecs[16] = mk(0, 6'h00, 0, 0, 1,   1,  0, 0, 0,  2'b00, 0, 2'b11, 0, 0);
        vecs[17] = mk(0, 6'h00, 1, 0, 1,   1,  1, 0, 0,  2'b00, 0, 2'b11, 0, 0);
        vecs[18] = mk(0, 6'h00, 0, 0, 1,   0,  0, 1, 1,  2'b01, 0, 2'b11, 1, 0);
        vecs[19] = mk(0, 6'h00, 0, 0, 0,   0,  0, 0, 0,  2'b00, 0, 2'b11, 1, 0);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].s, vecs[i].op, vecs[i].tk, vecs[i].rs);
            check_outs($sformatf("vec%0d", i), vecs[i].busy, vecs[i].alu, vecs[i].en,
                       vecs[i].dn, vecs[i].pcw, vecs[i].pcs, vecs[i].inv, vecs[i].cop,
                       vecs[i].t, vecs[i].n);
            $display("vec %0d: start=%0b op=%h taken=%0b reset=%0b -> busy=%0b done=%0b pc_write=%0b cmp_op=%0d",
                     i, start, opcode, taken, reset, bus_a.busy, bus_a.done, bus_a.pc_write, bus_a.cmp_op);
            advance();
        end

        // Four more taken BEQs: narrow counter pins at 3, wide one keeps counting
        for (int k = 0; k < 4; k++) begin
            drive(1, 6'h04, 0, 0); advance();
            drive(0, 6'h04, 0, 0); advance();
            drive(0, 6'h04, 1, 0); advance();
            drive(0, 6'h04, 0, 0);
            chk("sat.done", bus_a.done, 1);
            advance();
            $display("sat branch %0d: taken_cnt wide=%0d narrow=%0d", k, bus_a.taken_cnt, bus_b.taken_cnt);
        end
        drive(0, 6'h00, 0, 0);
        chk("sat.narrow_taken", bus_b.taken_cnt, 3);
        chk("sat.wide_taken",   bus_a.taken_cnt, 5);
        chk("sat.narrow_nt",    bus_b.nt_cnt,    0);
        advance();

        for (int i = 0; i < 3000; i++) begin
            bit       rs;
            bit       s;
            bit [5:0] op;
            bit       tk;
            rs = ($urandom_range(0, 59) == 0);
            s  = 1'($urandom_range(0, 1));
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(6'h04 + $urandom_range(0, 3));
            tk = 1'($urandom_range(0, 1));
            drive(s, op, tk, rs);
            check_model($sformatf("rnd%0d", i));
            if (bus_a.done)
                $display("rnd %0d: branch resolved pc_write=%0b cmp_op=%0d taken_cnt=%0d nt_cnt=%0d",
                         i, bus_a.pc_write, bus_a.cmp_op, bus_a.taken_cnt, bus_a.nt_cnt);
            advance();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/branch_ctrl_fsm.md
BRANCH_CTRL_FSM -- requirements
Module: branch_ctrl_fsm

Interface
REQ-001 Parameter CNT_W, default 16: width of the taken/not-taken statistics counters.
REQ-002 Parameter BR_SRC, default 2'b01: pc_source code that selects the branch target (ALUOut).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  control-unit request: decoded instruction is a conditional branch.
REQ-006 opcode  input  6  instruction opcode; 6'h04 BEQ, 6'h05 BNE, 6'h06 BLE, 6'h07 BGT.
REQ-007 taken  input  1  branch-condition result returned by the condition gate (combinational from cmp_en/cmp_op).
REQ-008 alu_cmp  output  1  requests the ALU to perform the A-B compare (sets igual/maior).
REQ-009 cmp_en  output  1  enables the condition gate (its UC_control input).
REQ-010 cmp_op  output  2  condition select: 00 BEQ, 01 BNE, 10 BLE, 11 BGT.
REQ-011 pc_write  output  1  one-cycle PC write strobe.
REQ-012 pc_source  output  2  PC mux select; BR_SRC when pc_write=1, else 2'b00.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when a branch resolves.
REQ-015 invalid  output  1  one-cycle pulse on start with a non-branch opcode.
REQ-016 taken_cnt, nt_cnt  output  CNT_W each  count of resolved taken / not-taken branches.

Function
REQ-017 The FSM SHALL have states IDLE, COMPARE, EVAL, WRITE; alu_cmp, cmp_en, pc_write, pc_source, busy and done are Moore outputs decoded from the registered state and captured registers.
REQ-018 In IDLE with start=1 and opcode in 6'h04..6'h07, the FSM SHALL latch cmp_op = opcode[1:0] and move to COMPARE.
REQ-019 In IDLE with start=1 and any other opcode, the FSM SHALL remain in IDLE and set invalid=1 for exactly the next cycle; cmp_op is unchanged.
REQ-020 COMPARE SHALL last one cycle with alu_cmp=1, then go to EVAL.
REQ-021 EVAL SHALL last one cycle with alu_cmp=1 and cmp_en=1; at the closing edge the FSM SHALL latch taken into an internal taken_r and go to WRITE.
REQ-022 WRITE SHALL last one cycle with done=1, pc_write=taken_r, and pc_source=BR_SRC if taken_r else 2'b00; the FSM then returns to IDLE.
REQ-023 Latency: start sampled at edge N gives COMPARE in cycle N+1, EVAL in N+2, WRITE (done) in N+3; the next start is accepted at the edge ending WRITE at the earliest.
REQ-024 start while busy=1 SHALL be ignored; no queueing, and invalid is not raised.
REQ-025 cmp_op SHALL hold its latched value from COMPARE through WRITE, regardless of opcode changes.
REQ-026 Changes on taken outside EVAL SHALL have no effect.
REQ-027 On entering WRITE, taken_cnt SHALL increment if taken_r=1, otherwise nt_cnt SHALL increment; each saturates at all-ones with no wrap.
REQ-028 In IDLE, alu_cmp, cmp_en, pc_write, done and busy SHALL be 0, and pc_source SHALL be 2'b00.

Reset
REQ-029 reset=1 SHALL force IDLE, cmp_op=2'b00, taken_r=0, invalid=0 and both counters to 0 on the next edge, including mid-operation; reset takes priority over start.
REQ-030 While reset is high, all outputs SHALL read as their IDLE values, and no pc_write or done may escape from an aborted branch.

Verification
REQ-031 BEQ taken: start, opcode=6'h04, taken=1 in EVAL -> cycle N+3 has pc_write=1, pc_source=01, done=1; taken_cnt=1.
REQ-032 BNE not taken: opcode=6'h05, taken=0 -> cycle N+3 has done=1, pc_write=0, pc_source=00; nt_cnt=1.
REQ-033 Invalid opcode 6'h23 with start -> invalid=1 for one cycle; busy stays 0; counters unchanged.
REQ-034 start pulsed in COMPARE and in EVAL with opcode=6'h07 -> ignored; exactly one done; cmp_op stays the first value.
REQ-035 reset asserted in EVAL -> IDLE next cycle; no pc_write or done; counters read 0.
REQ-036 With CNT_W=2, four taken branches -> taken_cnt saturates at 3.
